// File: rtl/i2s_dac_tx_if.sv
// Sample handshake between the audio sample source and the I2S transmitter.
// The source (master) offers a sample with sample_valid/sample_data.
// The transmitter (slave) accepts it while sample_ready is high.
interface i2s_dac_tx_if #(
  parameter int DATA_W = 16
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              sample_ready;

  modport master (
    output sample_valid,
    output sample_data,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    output sample_ready
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: buffers mono samples in a small FIFO and serialises each one,
// MSB first, onto AUD_DACDAT in I2S format. It runs as a slave to the codec's
// AUD_BCLK and AUD_DACLRCK, and the same sample is sent on left and right.
// Optional build macro I2S_HOLD_LAST_EN: on an underrun the last sample is
// repeated instead of sending silence.
module i2s_dac_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  i2s_dac_tx_if.slave      smp,
  input  logic             AUD_BCLK,
  input  logic             AUD_DACLRCK,
  output logic             AUD_DACDAT,
  output logic [LVL_W-1:0] fifo_level,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    WAIT_LEFT,
    ARM,
    SHIFT,
    PAD
  } state_t;

  // ---------------------------------------------------------------------
  // Codec pin synchronisers. Index 0 is LRCK and index 1 is BCLK.
  // ---------------------------------------------------------------------
  logic [1:0] pin_async;
  logic [1:0] pin_sync;
  logic [1:0] pin_hist;

  assign pin_async = {AUD_BCLK, AUD_DACLRCK};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [2:0] sh_reg;
      // Two synchroniser flops followed by one history flop.
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) sh_reg <= 3'b000;
        else          sh_reg <= {sh_reg[1:0], pin_async[gi]};
      end
      assign pin_sync[gi] = sh_reg[1];
      assign pin_hist[gi] = sh_reg[2];
    end
  endgenerate

  logic lr_sync;
  logic bclk_fall;
  logic unused_lr_hist;

  assign lr_sync   = pin_sync[0];
  assign bclk_fall = pin_hist[1] & ~pin_sync[1];
  // LRCK edges are judged against lr_prev, which advances on BCLK, so the
  // LRCK history flop has no consumer.
  assign unused_lr_hist = pin_hist[0];

  // ---------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;

  // ---------------------------------------------------------------------
  // Serial state
  // ---------------------------------------------------------------------
  state_t            state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              dacdat_reg;
  logic              lr_prev_reg;
  logic              underrun_reg;
  logic [7:0]        underrun_cnt_reg;

  logic push;
  logic fifo_empty;
  logic lr_change;
  logic left_edge;
  logic load_req;
  logic pop;
  logic underrun_evt;

  assign smp.sample_ready = (level_reg != LVL_W'(FIFO_DEPTH));
  assign push             = smp.sample_valid & smp.sample_ready;
  assign fifo_empty       = (level_reg == '0);
  assign lr_change        = lr_sync ^ lr_prev_reg;
  assign left_edge        = lr_prev_reg & ~lr_sync;
  // A new left word is requested from WAIT_LEFT, SHIFT (truncated word) or PAD.
  // A push in the same cycle is not visible to it, so an empty FIFO underruns.
  assign load_req         = bclk_fall & left_edge & (state_reg != ARM);
  assign pop              = load_req & ~fifo_empty;
  assign underrun_evt     = load_req & fifo_empty;

  // FIFO storage write port, left without reset so it maps onto RAM.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_reg] <= smp.sample_data;
  end

  // FIFO pointers and occupancy. The pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Word FSM plus hold register and underrun accounting. All outputs are registered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg        <= WAIT_LEFT;
      shift_reg        <= '0;
      hold_reg         <= '0;
      bit_cnt_reg      <= '0;
      dacdat_reg       <= 1'b0;
      lr_prev_reg      <= 1'b0;
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= 8'd0;
    end else begin
      underrun_reg <= 1'b0;
      if (underrun_evt) begin
        underrun_reg <= 1'b1;
        if (underrun_cnt_reg != 8'hFF) underrun_cnt_reg <= underrun_cnt_reg + 1'b1;
      end

      if (pop) hold_reg <= mem[rd_ptr_reg];
`ifdef I2S_HOLD_LAST_EN
      // On underrun the hold register keeps the previous sample, so it repeats.
`else
      else if (underrun_evt) hold_reg <= '0;
`endif

      if (bclk_fall) begin
        lr_prev_reg <= lr_sync;
        case (state_reg)
          WAIT_LEFT: begin
            dacdat_reg <= 1'b0;
            if (left_edge) state_reg <= ARM;
          end
          ARM: begin
            // One BCLK after the LRCK change: the MSB goes out now.
            shift_reg   <= hold_reg;
            bit_cnt_reg <= CNT_W'(DATA_W - 1);
            dacdat_reg  <= hold_reg[DATA_W-1];
            state_reg   <= SHIFT;
          end
          SHIFT: begin
            if (lr_change) begin
              // Frame shorter than the word: drop the remaining bits.
              dacdat_reg <= 1'b0;
              state_reg  <= ARM;
            end else begin
              dacdat_reg  <= shift_reg[DATA_W-2];
              shift_reg   <= shift_reg << 1;
              bit_cnt_reg <= bit_cnt_reg - 1'b1;
              if (bit_cnt_reg == CNT_W'(1)) state_reg <= PAD;
            end
          end
          PAD: begin
            dacdat_reg <= 1'b0;
            if (lr_change) state_reg <= ARM;
          end
          default: state_reg <= WAIT_LEFT;
        endcase
      end
    end
  end

  assign AUD_DACDAT   = dacdat_reg;
  assign fifo_level   = level_reg;
  assign underrun     = underrun_reg;
  assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Downstream of the mode data mux. Accepts 16-bit mono audio samples on a valid/ready handshake and buffers them in a small FIFO.
- Serialises each sample onto AUD_DACDAT in I2S format, as a slave to the codec-driven AUD_BCLK and AUD_DACLRCK.
- Sends the same sample on left and right.
- Replaces the bare serial path; the sample source paces writes at sample_clk rate and the FIFO absorbs jitter between the sample_clk and LRCK domains.

Parameters:
- DATA_W, 16, sample width in bits, MSB first.
- FIFO_DEPTH, 8, sample FIFO entries; power of 2, minimum 2.
- LVL_W, 4, fifo_level width; equals log2(FIFO_DEPTH)+1.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  DATA_W  two's-complement sample.
- sample_ready  out  1  FIFO can accept a sample.
- AUD_BCLK  in  1  codec bit clock, asynchronous to Clk.
- AUD_DACLRCK  in  1  codec word select, asynchronous to Clk; low = left.
- AUD_DACDAT  out  1  serial data to codec.
- fifo_level  out  LVL_W  current FIFO occupancy.
- underrun  out  1  one-Clk pulse when a left-word load finds the FIFO empty.
- underrun_cnt  out  8  saturating count of underruns.

Behaviour:
- Interface: one clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset values: AUD_DACDAT=0, sample_ready=1, fifo_level=0, underrun=0, underrun_cnt=0, FIFO empty, FSM=WAIT_LEFT, shift register=0, bit counter=0.
- Synchronisers: AUD_BCLK and AUD_DACLRCK each pass through a 2-flop synchroniser plus 1 history flop.
  - bclk_fall = sync_prev & ~sync.
  - All serial activity happens only on Clk cycles with bclk_fall.
  - Latency from a pin edge to the action is 3 Clk.
- FIFO:
  - Push when sample_valid & sample_ready.
  - sample_ready = (fifo_level != FIFO_DEPTH), combinational from a registered level.
  - Pop occurs only on a left-word load.
  - Push and pop in the same cycle leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - When full, sample_valid is ignored and data is dropped by the source's choice; no overwrite.
- lr_prev: registered copy of synced LRCK, updated on every bclk_fall.
- FSM, evaluated on bclk_fall only:
  - WAIT_LEFT:
    - AUD_DACDAT=0.
    - On lr_prev=1 and LRCK=0: pop the FIFO into the hold register if non-empty, else apply the underrun rule. Then go to ARM.
  - ARM:
    - Load the shift register from the hold register, set the bit counter to DATA_W-1, go to SHIFT.
    - AUD_DACDAT = MSB in this same bclk_fall cycle. This gives the I2S one-BCLK delay after the LRCK change.
  - SHIFT:
    - Each bclk_fall shifts left and drives the next bit; the counter decrements.
    - After the LSB has been driven, go to PAD.
  - PAD:
    - AUD_DACDAT=0.
    - On an LRCK change, go to ARM. A change to 0 pops first (new left); a change to 1 reuses the hold register (right = same sample).
  - LRCK change while in SHIFT (frame shorter than DATA_W+1 BCLKs): truncate the word; treat as in PAD (pop on change to 0), go to ARM.
- Underrun:
  - Hold register := 0; the word still transmits as zeros.
  - underrun pulses high for exactly 1 Clk.
  - underrun_cnt increments, saturating at 255.
- AUD_DACDAT is registered and changes only on bclk_fall cycles.
- Reset mid-word: all state clears immediately (async). AUD_DACDAT=0 until the first LRCK 1→0 after reset release; no partial word is ever emitted.
- A push and a left-load pop on the same cycle with FIFO empty: the pop sees empty (underrun); the pushed sample stays queued.

Optional Feature:
- Macro: I2S_HOLD_LAST_EN.
- Defined: on underrun, the hold register retains the previously sent sample (repeat last value) instead of zero. The underrun pulse and count behave identically.
- Undefined: the hold register is zeroed on underrun, as specified above.

Test Plan:
- Reset, then BCLK=3.125 MHz, LRCK=48.8 kHz (32 BCLK/channel), push 0xA5C3 → left and right words both MSB-first 1010_0101_1100_0011, MSB on 2nd BCLK fall after each LRCK edge, then zeros; underrun=0.
- Push 9 samples back-to-back with no LRCK activity → sample_ready drops after the 8th push, fifo_level=8, the 9th is not accepted; one left load → level=7, ready=1.
- No samples pushed, 3 left frames → AUD_DACDAT all 0, underrun pulses 3 times, underrun_cnt=3. With I2S_HOLD_LAST_EN after sending 0x7FFF: repeats 0x7FFF.
- Assert Reset_n=0 mid-SHIFT after 5 bits of 0xFFFF → AUD_DACDAT=0 immediately; FIFO empty; nothing emitted until the next LRCK fall; the next word is the next pushed sample.
- LRCK with 12 BCLK/channel, push 0x8001 → only the top 11 bits transmitted per channel, no hang; the next left load pops the next sample.
- Force underrun_cnt=255 via 256 empty frames → holds at 255.
